fu_seq_ctrl: RTL

- Command sequencer in front of the combinational functional unit (FU: a_in/b_in/fs_in -> f_out/z_out/n_out).
- Accepts one command over a valid/ready handshake. Runs the FU for one or more passes, feeding the FU result back for iterable ops, which gives multi-bit shifts and multi-step inc/dec.
- Returns the final f/z/n over a valid/ready response port.
- Sits between the issue logic and the FU instance in the datapath.

---
 rtl/fu_seq_ctrl_pkg.sv | 40 ++++
 rtl/fu_seq_ctrl_if.sv | 31 +++
 rtl/fu_seq_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/fu_seq_ctrl_pkg.sv
// Shared types for the functional-unit command sequencer: FU function codes,
// sequencer state names and helpers classifying the iterable operations.
package fu_seq_ctrl_pkg;

    localparam int FS_W = 4;

    typedef enum logic [FS_W-1:0] {
        FCLR  = 4'h0,
        FADD  = 4'h1,
        FSUB  = 4'h2,
        FAND  = 4'h3,
        FOR   = 4'h4,
        FXOR  = 4'h5,
        FNOT  = 4'h6,
        FMOVA = 4'h7,
        FMOVB = 4'h8,
        FINC  = 4'h9,
        FDEC  = 4'hA,
        FSHR  = 4'hB,
        FSRA  = 4'hC,
        FSLA  = 4'hD
    } fs_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fu_seq_state_t;

    // Ops whose result is fed back into the B operand on every extra pass.
    function automatic logic is_iter_b(input fs_t fs);
        return (fs == FSHR) || (fs == FSRA) || (fs == FSLA);
    endfunction

    // Ops whose result is fed back into the A operand on every extra pass.
    function automatic logic is_iter_a(input fs_t fs);
        return (fs == FINC) || (fs == FDEC);
    endfunction

endpackage

// File: rtl/fu_seq_ctrl_if.sv
// Command/response handshake bundle between the issue logic (master) and the
// FU sequencer (slave).
interface fu_seq_ctrl_if #(
    parameter int DW = 16,
    parameter int CW = 4
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_fs;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [CW-1:0] cmd_cnt;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_f;
    logic          rsp_z;
    logic          rsp_n;

    modport master (
        output cmd_valid, cmd_fs, cmd_a, cmd_b, cmd_cnt, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_f, rsp_z, rsp_n
    );

    modport slave (
        input  cmd_valid, cmd_fs, cmd_a, cmd_b, cmd_cnt, rsp_ready,
        output cmd_ready, rsp_valid, rsp_f, rsp_z, rsp_n
    );

endinterface

// File: rtl/fu_seq_ctrl.sv
// Sequencer in front of the combinational FU: takes one command, runs the FU
// for one or more passes with result feedback, and returns the final f/z/n.
module fu_seq_ctrl
    import fu_seq_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    fu_seq_ctrl_if.slave  bus,
    output logic          busy,
    output logic [DW-1:0] a_in,
    output logic [DW-1:0] b_in,
    output logic [3:0]    fs_in,
    input  logic [DW-1:0] f_out,
    input  logic          z_out,
    input  logic          n_out
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]    state;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    fs_t           fs_r;
    logic [CW-1:0] rem;
    logic [DW-1:0] f_r;
    logic          z_r;
    logic          n_r;

    fs_t           cmd_fs_e;
    logic          cmd_iter;
    logic [CW-1:0] cmd_passes;

    // Only iterable ops honour the count; a zero count still means one pass.
    always_comb begin
        cmd_fs_e   = fs_t'(bus.cmd_fs);
        cmd_iter   = is_iter_a(cmd_fs_e) || is_iter_b(cmd_fs_e);
        cmd_passes = CW'(1);
        if (cmd_iter && (bus.cmd_cnt != '0)) begin
            cmd_passes = bus.cmd_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            fs_r  <= FCLR;
            rem   <= '0;
            f_r   <= '0;
            z_r   <= 1'b0;
            n_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        a_r   <= bus.cmd_a;
                        b_r   <= bus.cmd_b;
                        fs_r  <= cmd_fs_e;
                        rem   <= cmd_passes;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rem == CW'(1)) begin
                        f_r   <= f_out;
                        z_r   <= z_out;
                        n_r   <= n_out;
                        state <= S_DONE;
                    end else begin
                        rem <= rem - CW'(1);
                        if (is_iter_a(fs_r)) begin
                            a_r <= f_out;
                        end
                        if (is_iter_b(fs_r)) begin
                            b_r <= f_out;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_DONE);
    assign bus.rsp_f     = f_r;
    assign bus.rsp_z     = z_r;
    assign bus.rsp_n     = n_r;
    assign busy          = (state != S_IDLE);

    // The FU sees the live operands at all times but only computes a real op in RUN.
    assign a_in  = a_r;
    assign b_in  = b_r;
    assign fs_in = (state == S_RUN) ? fs_r : FCLR;

endmodule
